sc_screen_sequencer: RTL and testbench
======================================

Name: sc_screen_sequencer

Overview:
Display-mode controller for the 8x8 LED matrix row multiplexer. It drives the multiplexer's 3-bit screen-select code from a game-flow state machine: splash, live play, one-row-down shift animation, blinking game-over, and win face. It sits between the game-logic flags and the row multiplexer, and times each animated screen with an internal prescaler.

Parameters:
TICK_DIV, 5000000, clock cycles per animation tick (>=2); 0.1 s at 50 MHz
DIV_WIDTH, 23, prescaler width; must satisfy 2^DIV_WIDTH >= TICK_DIV
SHIFT_TICKS, 2, ticks the shifted-down screen is held (>=1)
END_TICKS, 20, ticks the game-over/win screen is held (>=1)
TCNT_WIDTH, 5, tick-counter width; must satisfy 2^TCNT_WIDTH >= max(SHIFT_TICKS, END_TICKS)

Ports:
SC_SCREENSEQ_CLOCK_50  in  1  system clock, 50 MHz
SC_SCREENSEQ_RESET_InHigh  in  1  asynchronous reset, active high
SC_SCREENSEQ_start_InLow  in  1  start button, active low, already synchronised
SC_SCREENSEQ_shift_InHigh  in  1  request to play the row-shift animation
SC_SCREENSEQ_lose_InHigh  in  1  game lost flag
SC_SCREENSEQ_win_InHigh  in  1  game won flag
SC_SCREENSEQ_select_OutBUS  out  3  screen-select code to the row multiplexer
SC_SCREENSEQ_play_OutHigh  out  1  high while in PLAY
SC_SCREENSEQ_shiftDone_OutHigh  out  1  one-cycle pulse when a shift animation completes
SC_SCREENSEQ_endDone_OutHigh  out  1  one-cycle pulse on return to IDLE from LOSE or WIN
SC_SCREENSEQ_state_OutBUS  out  3  state code, for debug

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE (000), select = 000, play = 0, shiftDone = 0, endDone = 0, prescaler = 0, tick counter = 0, start history register = 1.
- Start detection uses a falling edge: an edge is a history value of 1 with current start = 0. If start is held low through reset release, no edge is seen until the button is released and pressed again.
- State codes and select values:
  - IDLE = 000, select 000 (splash).
  - PLAY = 001, select 001 (live data).
  - SHIFT = 010, select 010 (rows shifted down by one).
  - LOSE = 011, select 011 on even tick counts and 000 on odd tick counts (blink).
  - WIN = 100, select 100 (face).
- Select, play and the state code change in the same cycle as the state register (Moore outputs, registered).
- Timing:
  - Prescaler and tick counter clear on every state entry, and run only in SHIFT, LOSE and WIN.
  - Prescaler counts 0..TICK_DIV-1 and wraps. A tick fires when prescaler == TICK_DIV-1, and the tick counter increments on each tick.
- Transitions, checked in priority order:
  - IDLE: start edge -> PLAY. All other inputs are ignored.
  - PLAY: lose -> LOSE; else win -> WIN; else shift -> SHIFT. Lose and win in the same cycle -> LOSE.
  - SHIFT: lose -> LOSE; else win -> WIN. An aborted shift gives no shiftDone. Otherwise, on the final tick (tick counter == SHIFT_TICKS-1) -> PLAY, with shiftDone = 1 for exactly the first PLAY cycle. SHIFT therefore lasts exactly SHIFT_TICKS*TICK_DIV cycles. Shift requests arriving during SHIFT are dropped, not queued.
  - LOSE / WIN: all inputs are ignored. On the final tick (tick counter == END_TICKS-1) -> IDLE, with endDone = 1 for exactly the first IDLE cycle. Each state lasts END_TICKS*TICK_DIV cycles.
- A start edge in the same cycle as the return to IDLE is ignored; a new press is required.
- Asynchronous reset at any point forces the reset values immediately. No pulse is emitted.
- Unused state codes 101-111 recover to IDLE on the next clock with select = 000.

Test Plan:
All scenarios use TICK_DIV=4, SHIFT_TICKS=2, END_TICKS=3.
- Reset then start: hold start=1 for 2 cycles, then 0 -> select 000 until the edge, then 001 and play=1 on the next clock. Start held at 0 from reset -> stays in IDLE until released and pressed again.
- Shift in PLAY: shift=1 for one cycle -> select 010 for exactly 8 cycles, then 001 with shiftDone=1 for that single cycle. A second shift pulse mid-animation -> no extension.
- Lose blink: lose=1 in PLAY -> select 011 for 4 cycles, 000 for 4 cycles, 011 for 4 cycles, then IDLE (select 000) with endDone=1 for one cycle and play=0 throughout.
- Priority and abort: lose=1 and win=1 together in PLAY -> LOSE. win=1 at cycle 3 of SHIFT -> select 100 next cycle, no shiftDone pulse, and WIN held for 12 cycles.
- Asynchronous reset mid-WIN: assert reset between clock edges -> select, play and state go to 000 without waiting for a clock. After release, IDLE holds until a fresh start edge.

Source files
------------

// File: rtl/sc_screen_sequencer.sv
// sc_screen_sequencer: game-flow state machine driving the 8x8 LED matrix screen-select code
//   Parameters : TICK_DIV clocks per animation tick, SHIFT_TICKS / END_TICKS ticks held in
//                SHIFT and LOSE/WIN, DIV_WIDTH / TCNT_WIDTH counter widths.
//   Inputs     : SC_SCREENSEQ_CLOCK_50 clock, SC_SCREENSEQ_RESET_InHigh async reset,
//                SC_SCREENSEQ_start_InLow start button (active low), shift/lose/win game flags.
//   Outputs    : SC_SCREENSEQ_select_OutBUS screen code to the row mux, play level,
//                shiftDone / endDone one-cycle pulses, state code for debug. All registered.
module sc_screen_sequencer #(
  parameter int TICK_DIV    = 5000000,
  parameter int DIV_WIDTH   = 23,
  parameter int SHIFT_TICKS = 2,
  parameter int END_TICKS   = 20,
  parameter int TCNT_WIDTH  = 5
) (
  input  logic       SC_SCREENSEQ_CLOCK_50,
  input  logic       SC_SCREENSEQ_RESET_InHigh,
  input  logic       SC_SCREENSEQ_start_InLow,
  input  logic       SC_SCREENSEQ_shift_InHigh,
  input  logic       SC_SCREENSEQ_lose_InHigh,
  input  logic       SC_SCREENSEQ_win_InHigh,
  output logic [2:0] SC_SCREENSEQ_select_OutBUS,
  output logic       SC_SCREENSEQ_play_OutHigh,
  output logic       SC_SCREENSEQ_shiftDone_OutHigh,
  output logic       SC_SCREENSEQ_endDone_OutHigh,
  output logic [2:0] SC_SCREENSEQ_state_OutBUS
);
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    PLAY  = 3'b001,
    SHIFT = 3'b010,
    LOSE  = 3'b011,
    WIN   = 3'b100
  } state_t;
  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  pre_q, pre_d;
  logic [TCNT_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [2:0]            select_q, select_d;
  logic                  play_q, play_d;
  logic                  shift_done_q, shift_done_d;
  logic                  end_done_q, end_done_d;
  logic                  hist_q, armed_q;
  logic                  start_edge, tick, shift_last, end_last, timed;
  // armed_q only sets once the button has been seen released after reset, so a
  // button held down through reset release cannot masquerade as a fresh press.
  assign start_edge = armed_q & hist_q & ~SC_SCREENSEQ_start_InLow;
  assign tick       = pre_q == DIV_WIDTH'(TICK_DIV - 1);
  assign shift_last = tick && tcnt_q == TCNT_WIDTH'(SHIFT_TICKS - 1);
  assign end_last   = tick && tcnt_q == TCNT_WIDTH'(END_TICKS - 1);
  always_comb begin
    state_d      = state_q;
    shift_done_d = 1'b0;
    end_done_d   = 1'b0;
    case (state_q)
      IDLE:  state_d = start_edge ? PLAY : IDLE;
      PLAY:  state_d = SC_SCREENSEQ_lose_InHigh ? LOSE :
                       SC_SCREENSEQ_win_InHigh  ? WIN  :
                       SC_SCREENSEQ_shift_InHigh ? SHIFT : PLAY;
      SHIFT: begin
        state_d      = SC_SCREENSEQ_lose_InHigh ? LOSE :
                       SC_SCREENSEQ_win_InHigh  ? WIN  :
                       shift_last ? PLAY : SHIFT;
        shift_done_d = !SC_SCREENSEQ_lose_InHigh && !SC_SCREENSEQ_win_InHigh && shift_last;
      end
      LOSE, WIN: begin
        state_d    = end_last ? IDLE : state_q;
        end_done_d = end_last;
      end
      default: state_d = IDLE;
    endcase
    // Counters run only while staying in an animated state; any state entry clears them.
    timed    = state_d == state_q && (state_q == SHIFT || state_q == LOSE || state_q == WIN);
    pre_d    = (!timed || tick) ? '0 : pre_q + DIV_WIDTH'(1);
    tcnt_d   = !timed ? '0 : tcnt_q + TCNT_WIDTH'(tick);
    // LOSE blinks: blank screen on odd tick counts.
    select_d = (state_d == LOSE && tcnt_d[0]) ? 3'b000 : 3'(state_d);
    play_d   = state_d == PLAY;
  end
  always_ff @(posedge SC_SCREENSEQ_CLOCK_50 or posedge SC_SCREENSEQ_RESET_InHigh) begin
    if (SC_SCREENSEQ_RESET_InHigh) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      tcnt_q       <= '0;
      select_q     <= 3'b000;
      play_q       <= 1'b0;
      shift_done_q <= 1'b0;
      end_done_q   <= 1'b0;
      hist_q       <= 1'b1;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      tcnt_q       <= tcnt_d;
      select_q     <= select_d;
      play_q       <= play_d;
      shift_done_q <= shift_done_d;
      end_done_q   <= end_done_d;
      hist_q       <= SC_SCREENSEQ_start_InLow;
      armed_q      <= armed_q | SC_SCREENSEQ_start_InLow;
    end
  end
  assign SC_SCREENSEQ_select_OutBUS     = select_q;
  assign SC_SCREENSEQ_play_OutHigh      = play_q;
  assign SC_SCREENSEQ_shiftDone_OutHigh = shift_done_q;
  assign SC_SCREENSEQ_endDone_OutHigh   = end_done_q;
  assign SC_SCREENSEQ_state_OutBUS      = state_q;
endmodule

// File: tb/tb_sc_screen_sequencer.sv
// tb_sc_screen_sequencer: directed scenarios plus randomized run against a cycle-count reference model
module tb_sc_screen_sequencer;
  localparam int TICK_DIV = 4;
  localparam int SHIFT_TICKS = 2;
  localparam int END_TICKS = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b1;
  logic shift = 1'b0;
  logic lose = 1'b0;
  logic win = 1'b0;
  logic [2:0] sel, st;
  logic play, sd, ed;
  int n_cmp = 0;
  int n_err = 0;
  sc_screen_sequencer #(
    .TICK_DIV(TICK_DIV), .DIV_WIDTH(3), .SHIFT_TICKS(SHIFT_TICKS),
    .END_TICKS(END_TICKS), .TCNT_WIDTH(2)
  ) dut (
    .SC_SCREENSEQ_CLOCK_50(clk),
    .SC_SCREENSEQ_RESET_InHigh(rst),
    .SC_SCREENSEQ_start_InLow(start),
    .SC_SCREENSEQ_shift_InHigh(shift),
    .SC_SCREENSEQ_lose_InHigh(lose),
    .SC_SCREENSEQ_win_InHigh(win),
    .SC_SCREENSEQ_select_OutBUS(sel),
    .SC_SCREENSEQ_play_OutHigh(play),
    .SC_SCREENSEQ_shiftDone_OutHigh(sd),
    .SC_SCREENSEQ_endDone_OutHigh(ed),
    .SC_SCREENSEQ_state_OutBUS(st)
  );
  always #5 clk = ~clk;
  // Reference model: state number plus cycles spent in it; durations are whole-cycle counts.
  int m_st, m_cyc, m_ns, m_nc;
  bit m_prev, m_rel, m_nsd, m_ned, m_play, m_sd, m_ed;
  logic [2:0] m_sel;
  always_comb begin
    m_ns = m_st;
    m_nsd = 1'b0;
    m_ned = 1'b0;
    if (m_st == 0) begin
      if (m_rel && m_prev && !start) m_ns = 1;
    end else if (m_st == 1 || m_st == 2) begin
      if (lose) m_ns = 3;
      else if (win) m_ns = 4;
      else if (m_st == 1 && shift) m_ns = 2;
      else if (m_st == 2 && m_cyc == SHIFT_TICKS * TICK_DIV - 1) begin
        m_ns = 1;
        m_nsd = 1'b1;
      end
    end else if (m_st == 3 || m_st == 4) begin
      if (m_cyc == END_TICKS * TICK_DIV - 1) begin
        m_ns = 0;
        m_ned = 1'b1;
      end
    end else m_ns = 0;
    m_nc = (m_ns == m_st) ? m_cyc + 1 : 0;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 0; m_cyc <= 0; m_prev <= 1'b1; m_rel <= 1'b0;
      m_sel <= 3'd0; m_play <= 1'b0; m_sd <= 1'b0; m_ed <= 1'b0;
    end else begin
      m_st <= m_ns;
      m_cyc <= m_nc;
      m_prev <= start;
      m_rel <= m_rel | start;
      m_sel <= (m_ns == 3 && ((m_nc / TICK_DIV) % 2) == 1) ? 3'd0 : 3'(m_ns);
      m_play <= m_ns == 1;
      m_sd <= m_nsd;
      m_ed <= m_ned;
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; start = 1'b1; shift = 1'b0; lose = 1'b0; win = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
  endtask
  task automatic go_play();
    do_reset();
    step(1);
    start = 1'b0;
    step(1);
    start = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({sel, play, sd, ed, st} !== 9'd0) begin
      n_err++;
      $display("FAIL reset: got sel=%b play=%b sd=%b ed=%b st=%b, want all zero", sel, play, sd, ed, st);
    end
  endtask
  task automatic test_start();
    do_reset();
    step(2);
    n_cmp++;
    if (sel !== 3'b000) begin n_err++; $display("FAIL start_pre: sel=%b want 000", sel); end
    start = 1'b0;
    step(1);
    n_cmp++;
    if ({sel, play, st} !== {3'b001, 1'b1, 3'b001}) begin
      n_err++; $display("FAIL start_edge: sel=%b play=%b st=%b want 001/1/001", sel, play, st);
    end
    rst = 1'b1; start = 1'b0;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_cmp++;
      if (st !== 3'b000) begin n_err++; $display("FAIL start_held: st=%b want 000", st); end
    end
    start = 1'b1;
    step(1);
    n_cmp++;
    if (st !== 3'b000) begin n_err++; $display("FAIL start_release: st=%b want 000", st); end
    start = 1'b0;
    step(1);
    n_cmp++;
    if ({play, st} !== {1'b1, 3'b001}) begin
      n_err++; $display("FAIL start_repress: play=%b st=%b want 1/001", play, st);
    end
    start = 1'b1;
  endtask
  task automatic test_shift();
    go_play();
    shift = 1'b1;
    step(1);
    shift = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({sel, sd, play} !== {3'b010, 1'b0, 1'b0}) begin
        n_err++; $display("FAIL shift_hold[%0d]: sel=%b sd=%b play=%b want 010/0/0", i, sel, sd, play);
      end
      shift = (i == 3);
      step(1);
    end
    n_cmp++;
    if ({sel, sd, play} !== {3'b001, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL shift_done: sel=%b sd=%b play=%b want 001/1/1", sel, sd, play);
    end
    step(1);
    n_cmp++;
    if ({sel, sd} !== {3'b001, 1'b0}) begin
      n_err++; $display("FAIL shift_pulse: sel=%b sd=%b want 001/0", sel, sd);
    end
  endtask
  task automatic test_lose();
    go_play();
    lose = 1'b1;
    step(1);
    lose = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({sel, play, ed, st} !== {(((i / 4) % 2) == 1) ? 3'b000 : 3'b011, 1'b0, 1'b0, 3'b011}) begin
        n_err++; $display("FAIL lose_blink[%0d]: sel=%b play=%b ed=%b st=%b", i, sel, play, ed, st);
      end
      step(1);
    end
    n_cmp++;
    if ({sel, play, ed, st} !== {3'b000, 1'b0, 1'b1, 3'b000}) begin
      n_err++; $display("FAIL lose_end: sel=%b play=%b ed=%b st=%b want 000/0/1/000", sel, play, ed, st);
    end
    step(1);
    n_cmp++;
    if ({ed, st} !== {1'b0, 3'b000}) begin
      n_err++; $display("FAIL lose_pulse: ed=%b st=%b want 0/000", ed, st);
    end
  endtask
  task automatic test_priority_abort();
    go_play();
    lose = 1'b1; win = 1'b1;
    step(1);
    lose = 1'b0; win = 1'b0;
    n_cmp++;
    if (st !== 3'b011) begin n_err++; $display("FAIL prio_lose: st=%b want 011", st); end
    go_play();
    shift = 1'b1;
    step(1);
    shift = 1'b0;
    step(2);
    win = 1'b1;
    step(1);
    win = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if ({sel, sd, st} !== {3'b100, 1'b0, 3'b100}) begin
        n_err++; $display("FAIL abort_win[%0d]: sel=%b sd=%b st=%b want 100/0/100", i, sel, sd, st);
      end
      step(1);
    end
    n_cmp++;
    if ({st, ed} !== {3'b000, 1'b1}) begin
      n_err++; $display("FAIL win_end: st=%b ed=%b want 000/1", st, ed);
    end
  endtask
  task automatic test_async_reset();
    go_play();
    win = 1'b1;
    step(1);
    win = 1'b0;
    step(3);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({sel, play, st} !== 7'd0) begin
      n_err++; $display("FAIL async_reset: sel=%b play=%b st=%b want 000/0/000", sel, play, st);
    end
    @(negedge clk);
    rst = 1'b0;
    step(3);
    n_cmp++;
    if ({sel, st, ed} !== 7'd0) begin
      n_err++; $display("FAIL async_idle: sel=%b st=%b ed=%b want 000/000/0", sel, st, ed);
    end
    start = 1'b0;
    step(1);
    start = 1'b1;
    n_cmp++;
    if ({play, st} !== {1'b1, 3'b001}) begin
      n_err++; $display("FAIL async_restart: play=%b st=%b want 1/001", play, st);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      n_cmp++;
      if ({sel, play, sd, ed, st} !== {m_sel, m_play, m_sd, m_ed, 3'(m_st)}) begin
        n_err++;
        $display("FAIL random[%0d]: got sel=%b play=%b sd=%b ed=%b st=%b want sel=%b play=%b sd=%b ed=%b st=%b",
                 c, sel, play, sd, ed, st, m_sel, m_play, m_sd, m_ed, 3'(m_st));
      end
      start = $urandom_range(0, 3) != 0;
      shift = $urandom_range(0, 5) == 0;
      lose = $urandom_range(0, 49) == 0;
      win = $urandom_range(0, 49) == 0;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
      step(1);
    end
  endtask
  initial begin
    test_reset();
    test_start();
    test_shift();
    test_lose();
    test_priority_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
